// File: rtl/pe_writeback_rf.sv
// ============================================================================
// Module      : pe_writeback_rf
// Description : PE writeback stage. Commits FU results into a local register
//               file, predicate register and neighbour output register, and
//               serves two combinational operand read ports. Optional macro
//               WB_BYPASS_EN forwards same-cycle writes to the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_writeback_rf #(
  parameter int DATA_W   = 32,
  parameter int RF_DEPTH = 8,
  parameter int ADDR_W   = 3,
  parameter int PRED_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fu_valid,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [PRED_W-1:0] wb_pred,
  input  logic              write_back,
  input  logic              write_back_p,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              out_en,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [PRED_W-1:0] pred_q,
  output logic [DATA_W-1:0] out_reg,
  output logic              out_valid,
  output logic [15:0]       wr_count
);

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  logic [DATA_W-1:0] r_rf [RF_DEPTH];
  logic [PRED_W-1:0] r_pred;
  logic [DATA_W-1:0] r_out;
  logic              r_out_valid;
  logic [15:0]       r_wr_count;

  logic              w_data_commit;
  logic              w_pred_commit;
  logic              w_out_commit;
  logic [DATA_W-1:0] w_ra_rf;
  logic [DATA_W-1:0] w_rb_rf;

  // Addresses beyond RF_DEPTH (only possible when RF_DEPTH < 2**ADDR_W)
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(RF_DEPTH));
  endfunction

  assign w_data_commit = fu_valid & write_back;
  assign w_pred_commit = fu_valid & write_back_p;
  assign w_out_commit  = fu_valid & write_back & out_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        r_rf[i] <= '0;
      end
      r_pred      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_wr_count  <= '0;
    end else begin
      if (w_data_commit && in_range(rd_addr)) begin
        r_rf[rd_addr] <= wb_value;
      end
      if (w_data_commit && (r_wr_count != C_CNT_MAX)) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
      if (w_pred_commit) begin
        r_pred <= wb_pred;
      end
      if (w_out_commit) begin
        r_out <= wb_value;
      end
      r_out_valid <= w_out_commit;
    end
  end

  assign w_ra_rf = in_range(ra_addr) ? r_rf[ra_addr] : '0;
  assign w_rb_rf = in_range(rb_addr) ? r_rf[rb_addr] : '0;

`ifdef WB_BYPASS_EN
  // Forward only writes that will actually land, so reset still wins
  logic w_fwd_ok;
  assign w_fwd_ok = ~rst & w_data_commit & in_range(rd_addr);
  assign ra_data  = (w_fwd_ok && (ra_addr == rd_addr)) ? wb_value : w_ra_rf;
  assign rb_data  = (w_fwd_ok && (rb_addr == rd_addr)) ? wb_value : w_rb_rf;
  assign pred_q   = (~rst & w_pred_commit) ? wb_pred : r_pred;
`else
  assign ra_data  = w_ra_rf;
  assign rb_data  = w_rb_rf;
  assign pred_q   = r_pred;
`endif

  assign out_reg   = r_out;
  assign out_valid = r_out_valid;
  assign wr_count  = r_wr_count;

endmodule

`default_nettype wire

// File: tb/tb_pe_writeback_rf.sv
// ============================================================================
// Module      : tb_pe_writeback_rf
// Description : Directed and randomized bench for pe_writeback_rf against a
//               behavioural register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_writeback_rf;

  logic        clk = 1'b0;
  logic        rst;
  logic        fu_valid;
  logic [31:0] wb_value;
  logic [3:0]  wb_pred;
  logic        write_back;
  logic        write_back_p;
  logic [2:0]  rd_addr;
  logic        out_en;
  logic [2:0]  ra_addr;
  logic [2:0]  rb_addr;
  logic [31:0] ra_data;
  logic [31:0] rb_data;
  logic [3:0]  pred_q;
  logic [31:0] out_reg;
  logic        out_valid;
  logic [15:0] wr_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_rf [8];
  logic [3:0]  m_pred;
  logic [31:0] m_out;
  logic        m_outv;
  int          m_cnt;

  always #5 clk = ~clk;

  pe_writeback_rf dut (
    .clk          (clk),
    .rst          (rst),
    .fu_valid     (fu_valid),
    .wb_value     (wb_value),
    .wb_pred      (wb_pred),
    .write_back   (write_back),
    .write_back_p (write_back_p),
    .rd_addr      (rd_addr),
    .out_en       (out_en),
    .ra_addr      (ra_addr),
    .rb_addr      (rb_addr),
    .ra_data      (ra_data),
    .rb_data      (rb_data),
    .pred_q       (pred_q),
    .out_reg      (out_reg),
    .out_valid    (out_valid),
    .wr_count     (wr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value a read port should show this cycle, given the current inputs
  function automatic logic [31:0] exp_read(input logic [2:0] a);
`ifdef WB_BYPASS_EN
    if (!rst && fu_valid && write_back && (rd_addr == a)) return wb_value;
`endif
    return m_rf[a];
  endfunction

  function automatic logic [3:0] exp_pred();
`ifdef WB_BYPASS_EN
    if (!rst && fu_valid && write_back_p) return wb_pred;
`endif
    return m_pred;
  endfunction

  // One clock: check reads before the edge, update model, check registers after
  task automatic cycle();
    @(negedge clk);
    chk("ra_data", ra_data, exp_read(ra_addr));
    chk("rb_data", rb_data, exp_read(rb_addr));
    chk("pred_q", {28'd0, pred_q}, {28'd0, exp_pred()});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      m_pred = '0;
      m_out  = '0;
      m_outv = 1'b0;
      m_cnt  = 0;
    end else begin
      if (fu_valid && write_back) begin
        m_rf[rd_addr] = wb_value;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
      if (fu_valid && write_back_p) m_pred = wb_pred;
      m_outv = fu_valid && write_back && out_en;
      if (m_outv) m_out = wb_value;
    end
    #1;
    chk("out_reg", out_reg, m_out);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_outv});
    chk("wr_count", {16'd0, wr_count}, m_cnt[31:0]);
  endtask

  task automatic idle();
    fu_valid = 0; write_back = 0; write_back_p = 0; out_en = 0;
  endtask

  task automatic commit(input logic [2:0] a, input logic [31:0] v,
                        input logic wbp, input logic [3:0] p, input logic oe);
    fu_valid = 1; write_back = 1; write_back_p = wbp;
    rd_addr = a; wb_value = v; wb_pred = p; out_en = oe;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_pred = '0; m_out = '0; m_outv = 0; m_cnt = 0;
    rst = 1; idle(); wb_value = 0; wb_pred = 0; rd_addr = 0; ra_addr = 0; rb_addr = 0;
    cycle();
    rst = 0;

    // Preload, then reset must clear everything
    commit(3'd0, 32'h1234, 0, 4'd0, 1); cycle();
    commit(3'd7, 32'h1234, 0, 4'd0, 0); cycle();
    idle(); ra_addr = 0; rb_addr = 7; cycle();
    rst = 1; cycle();
    rst = 0; cycle();
    chk("reset_ra", ra_data, 32'h0);
    chk("reset_rb", rb_data, 32'h0);
    chk("reset_cnt", {16'd0, wr_count}, 32'h0);

    // Basic commit of a negative value
    commit(3'd3, 32'hFFFF_FFF6, 0, 4'd0, 0); cycle();
    idle(); ra_addr = 3; cycle();
    chk("basic_ra", ra_data, 32'hFFFF_FFF6);
    chk("basic_cnt", {16'd0, wr_count}, 32'd1);

    // fu_valid gating, then out_en without write_back
    fu_valid = 0; write_back = 1; write_back_p = 1; rd_addr = 2; wb_value = 7; wb_pred = 1;
    ra_addr = 2; cycle(); cycle();
    fu_valid = 1; write_back = 0; write_back_p = 0; out_en = 1; cycle();
    chk("gate_outv", {31'd0, out_valid}, 32'd0);

    // Simultaneous data / predicate / output commit
    commit(3'd5, 32'd42, 1, 4'd1, 1); cycle();
    chk("sim_outv", {31'd0, out_valid}, 32'd1);
    idle(); ra_addr = 5; rb_addr = 5; cycle();
    chk("sim_outv_drop", {31'd0, out_valid}, 32'd0);

    // Same-cycle read of the written address
    commit(3'd4, 32'd99, 0, 4'd0, 0); ra_addr = 4; rb_addr = 4; cycle();
    idle(); cycle();
    chk("raw_next", ra_data, 32'd99);

    // Reset dominates a coincident commit
    commit(3'd1, 32'h55, 1, 4'hA, 1); rst = 1; cycle();
    rst = 0; idle(); ra_addr = 1; cycle();
    chk("rst_prio", ra_data, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 39) == 0);
      fu_valid     = $urandom_range(0, 3) != 0;
      write_back   = $urandom_range(0, 1);
      write_back_p = $urandom_range(0, 1);
      out_en       = $urandom_range(0, 1);
      rd_addr      = 3'($urandom_range(0, 7));
      ra_addr      = ($urandom_range(0, 2) == 0) ? rd_addr : 3'($urandom_range(0, 7));
      rb_addr      = 3'($urandom_range(0, 7));
      wb_value     = $urandom;
      wb_pred      = 4'($urandom_range(0, 15));
      cycle();
    end
    rst = 0;

    // Counter saturation
    rst = 1; idle(); cycle(); rst = 0;
    for (int n = 0; n < 65540; n++) begin
      commit(3'($urandom_range(0, 7)), $urandom, 0, 4'd0, 0);
      ra_addr = rd_addr;
      cycle();
    end
    idle(); cycle();
    chk("sat_cnt", {16'd0, wr_count}, 32'h0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
